// File: rtl/fp_norm_pkg.sv
// rtl/fp_norm_pkg.sv - widths and stage types for the fp_norm_pipe normaliser
package fp_norm_pkg;
    localparam int MAN_WIDTH = 24;
    localparam int EXP_WIDTH = 8;
    localparam int CNT_WIDTH = 6;

    typedef logic signed [EXP_WIDTH+1:0] exp_t;
    typedef logic [MAN_WIDTH-1:0]        mant_t;
    typedef logic [CNT_WIDTH-1:0]        cnt_t;

    typedef struct packed {
        logic  valid;
        logic  sign;
        exp_t  exp;
        mant_t mant;
        logic  zero;
        logic  uf;
    } norm_stage_t;
endpackage

// File: rtl/lzc.sv
// rtl/lzc.sv - combinational leading (MODE=1) or trailing (MODE=0) zero counter
module lzc #(
    parameter int WIDTH     = 24,
    parameter bit MODE      = 1'b1,
    parameter int CNT_WIDTH = 6
) (
    input  logic [WIDTH-1:0]     data,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 empty
);
    always_comb begin
        cnt   = '0;
        empty = 1'b1;
        // Later hits overwrite earlier ones, so the scan order picks the bit nearest the counted end.
        for (int i = 0; i < WIDTH; i++) begin
            if (MODE) begin
                if (data[i]) begin
                    cnt   = CNT_WIDTH'(WIDTH - 1 - i);
                    empty = 1'b0;
                end
            end else begin
                if (data[WIDTH-1-i]) begin
                    cnt   = CNT_WIDTH'(WIDTH - 1 - i);
                    empty = 1'b0;
                end
            end
        end
    end
endmodule

// File: rtl/fp_norm_pipe.sv
// rtl/fp_norm_pipe.sv - 2-stage mantissa normaliser; NORM_SUBNORMAL_EN limits the shift to keep exp >= 1
module fp_norm_pipe
    import fp_norm_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  flush_i,
    input  logic  in_valid_i,
    output logic  in_ready_o,
    input  logic  sign_i,
    input  exp_t  exp_i,
    input  mant_t mant_i,
    output logic  out_valid_o,
    input  logic  out_ready_i,
    output logic  sign_o,
    output exp_t  exp_o,
    output mant_t mant_o,
    output logic  zero_o,
    output logic  underflow_o
);
    logic        s0_valid;
    logic        s0_sign;
    exp_t        s0_exp;
    mant_t       s0_mant;
    norm_stage_t s1;

    cnt_t  lz;
    logic  empty;
    cnt_t  shift;
    mant_t sh_mant;
    exp_t  adj_exp;
    logic  nxt_uf;
    logic  s1_ready;

    lzc #(.WIDTH(MAN_WIDTH), .MODE(1'b1), .CNT_WIDTH(CNT_WIDTH)) u_lzc (
        .data  (s0_mant),
        .cnt   (lz),
        .empty (empty)
    );

    assign s1_ready   = !s1.valid || out_ready_i;
    assign in_ready_o = !s0_valid || s1_ready;

    always_comb begin
        shift  = lz;
        nxt_uf = 1'b0;
`ifdef NORM_SUBNORMAL_EN
        if (s0_exp <= exp_t'(1))
            shift = '0;
        else if (exp_t'(lz) > s0_exp - exp_t'(1))
            shift = cnt_t'(s0_exp - exp_t'(1));
`endif
        sh_mant = s0_mant << shift;
        adj_exp = s0_exp - exp_t'(shift);
`ifdef NORM_SUBNORMAL_EN
        if (!sh_mant[MAN_WIDTH-1])
            adj_exp = '0;
`else
        nxt_uf = adj_exp < exp_t'(1);
`endif
        if (empty) begin
            sh_mant = '0;
            adj_exp = '0;
            nxt_uf  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s0_valid <= 1'b0;
            s0_sign  <= 1'b0;
            s0_exp   <= '0;
            s0_mant  <= '0;
            s1       <= '0;
        end else begin
            if (flush_i)
                s0_valid <= 1'b0;
            else if (in_ready_o)
                s0_valid <= in_valid_i;
            if (!flush_i && in_valid_i && in_ready_o) begin
                s0_sign <= sign_i;
                s0_exp  <= exp_i;
                s0_mant <= mant_i;
            end
            // Data registers only move on a real transfer so a stalled output stays stable.
            if (flush_i)
                s1.valid <= 1'b0;
            else if (s1_ready)
                s1.valid <= s0_valid;
            if (!flush_i && s1_ready && s0_valid) begin
                s1.sign <= s0_sign;
                s1.exp  <= adj_exp;
                s1.mant <= sh_mant;
                s1.zero <= empty;
                s1.uf   <= nxt_uf;
            end
        end
    end

    assign out_valid_o = s1.valid;
    assign sign_o      = s1.sign;
    assign exp_o       = s1.exp;
    assign mant_o      = s1.mant;
    assign zero_o      = s1.zero;
    assign underflow_o = s1.uf;
endmodule
